// File: rtl/line_window_3x3.sv
// Streaming 3x3 window generator: two IMG_W-deep line buffers plus per-row taps.
// Optional coordinate outputs (out_x/out_y) are built when LINE_WINDOW_COORD_EN is defined.
module line_window_3x3 #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 258,
  parameter int IMG_H  = 34
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         pixel_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         pixelr1,
  output logic [DATA_W-1:0]         pixelr2,
  output logic [DATA_W-1:0]         pixelr3,
  output logic [DATA_W-1:0]         pixelr4,
  output logic [DATA_W-1:0]         pixelr5,
  output logic [DATA_W-1:0]         pixelr6,
  output logic [DATA_W-1:0]         pixelr7,
  output logic [DATA_W-1:0]         pixelr8,
  output logic [DATA_W-1:0]         pixelr9,
`ifdef LINE_WINDOW_COORD_EN
  output logic [$clog2(IMG_W)-1:0]  out_x,
  output logic [$clog2(IMG_H)-1:0]  out_y,
`endif
  output logic                      frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  // Handshake: in_ready = !out_valid || out_ready; a pixel moves on in_valid && in_ready,
  // a window moves on out_valid && out_ready; producers hold data stable until taken.

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] top_q [2];
  logic [DATA_W-1:0] mid_q [2];
  logic [DATA_W-1:0] bot_q [2];
  logic [DATA_W-1:0] lb0_rd;
  logic [DATA_W-1:0] lb1_rd;
  logic              accept;
  logic              win;
  logic              col_last;
  logic              row_last;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign lb0_rd   = lb0[col];
  assign lb1_rd   = lb1[col];
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  assign win      = (row >= RW'(2)) && (col >= CW'(2));

  // The third (newest) tap of each row is the live line-buffer read / input pixel,
  // so only the two older taps per row need storage.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0_rd;
      lb0[col] <= pixel_in;
      top_q[0] <= top_q[1];
      top_q[1] <= lb1_rd;
      mid_q[0] <= mid_q[1];
      mid_q[1] <= lb0_rd;
      bot_q[0] <= bot_q[1];
      bot_q[1] <= pixel_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      pixelr1    <= '0;
      pixelr2    <= '0;
      pixelr3    <= '0;
      pixelr4    <= '0;
      pixelr5    <= '0;
      pixelr6    <= '0;
      pixelr7    <= '0;
      pixelr8    <= '0;
      pixelr9    <= '0;
`ifdef LINE_WINDOW_COORD_EN
      out_x      <= '0;
      out_y      <= '0;
`endif
    end else if (accept) begin
      out_valid  <= win;
      frame_done <= win && col_last && row_last;
      if (win) begin
        pixelr1 <= top_q[0];
        pixelr2 <= top_q[1];
        pixelr3 <= lb1_rd;
        pixelr4 <= mid_q[0];
        pixelr5 <= mid_q[1];
        pixelr6 <= lb0_rd;
        pixelr7 <= bot_q[0];
        pixelr8 <= bot_q[1];
        pixelr9 <= pixel_in;
`ifdef LINE_WINDOW_COORD_EN
        out_x   <= col - CW'(1);
        out_y   <= row - RW'(1);
`endif
      end
    end else if (out_ready) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

  // Taps are read before being shifted, so the stored pair holds columns c-2 and c-1.
  // (top_q[0] etc. above are the pre-shift values in the same clock.)

endmodule

// File: tb/tb_line_window_3x3.sv
// Self-checking bench for line_window_3x3 on a 6x5 frame; windows compared against a
// frame-array reference model. Coordinates checked when LINE_WINDOW_COORD_EN is defined.
module tb_line_window_3x3;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 6;
  localparam int IMG_H  = 5;
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
`ifdef LINE_WINDOW_COORD_EN
  localparam int WW     = 9 * DATA_W + 1 + CW + RW;
`else
  localparam int WW     = 9 * DATA_W + 1;
`endif

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] pixel_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] pixelr1, pixelr2, pixelr3, pixelr4, pixelr5;
  logic [DATA_W-1:0] pixelr6, pixelr7, pixelr8, pixelr9;
  logic              frame_done;
`ifdef LINE_WINDOW_COORD_EN
  logic [CW-1:0]     out_x;
  logic [RW-1:0]     out_y;
`endif

  line_window_3x3 #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .pixel_in(pixel_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pixelr1(pixelr1), .pixelr2(pixelr2), .pixelr3(pixelr3),
    .pixelr4(pixelr4), .pixelr5(pixelr5), .pixelr6(pixelr6),
    .pixelr7(pixelr7), .pixelr8(pixelr8), .pixelr9(pixelr9),
`ifdef LINE_WINDOW_COORD_EN
    .out_x(out_x), .out_y(out_y),
`endif
    .frame_done(frame_done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [WW-1:0]     exp_q[$];
  logic [WW-1:0]     obs_q[$];
  logic [DATA_W-1:0] img [IMG_H][IMG_W];
  int                n_cmp = 0;
  int                n_err = 0;
  int                obs_rd = 0;
  int                ov_cycles = 0;
  int                stall_bad = 0;
  int                ready_bad = 0;
  int                ready_mode = 0;
  int                timeouts = 0;

  function automatic logic [WW-1:0] dut_word();
`ifdef LINE_WINDOW_COORD_EN
    return {frame_done, pixelr1, pixelr2, pixelr3, pixelr4, pixelr5,
            pixelr6, pixelr7, pixelr8, pixelr9, out_x, out_y};
`else
    return {frame_done, pixelr1, pixelr2, pixelr3, pixelr4, pixelr5,
            pixelr6, pixelr7, pixelr8, pixelr9};
`endif
  endfunction

  // Monitor: records every transferred window and any stall/ready rule breaks.
  initial begin : monitor
    logic          prev_stall;
    logic [WW-1:0] prev_word;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_stall && !(out_valid === 1'b1 && dut_word() === prev_word)) stall_bad++;
        if (in_ready !== (!out_valid || out_ready)) ready_bad++;
        if (out_valid === 1'b1) ov_cycles++;
        if (out_valid === 1'b1 && out_ready === 1'b1) obs_q.push_back(dut_word());
        prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
        prev_word  = dut_word();
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Downstream ready driver: 0 = always, 1 = pattern 1,0,0,1, 2 = random.
  initial begin : ready_drv
    int ph;
    logic [3:0] pat;
    ph  = 0;
    pat = 4'b1001;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       begin out_ready = pat[ph % 4]; ph++; end
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- check helpers ----------------
  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic fill_img(input bit rnd);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = rnd ? DATA_W'($urandom) : DATA_W'(r * 16 + c);
  endtask

  // Every pixel at row>=2, col>=2 closes one window over img[r-2..r][c-2..c].
  task automatic expect_frame();
    logic fd;
    for (int r = 2; r < IMG_H; r++)
      for (int c = 2; c < IMG_W; c++) begin
        fd = (r == IMG_H - 1) && (c == IMG_W - 1);
`ifdef LINE_WINDOW_COORD_EN
        exp_q.push_back({fd, img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                         img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                         img[r][c-2], img[r][c-1], img[r][c],
                         CW'(c - 1), RW'(r - 1)});
`else
        exp_q.push_back({fd, img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                         img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                         img[r][c-2], img[r][c-1], img[r][c]});
`endif
      end
  endtask

  // ---------------- driver ----------------
  task automatic push_pixel(input logic [DATA_W-1:0] v, input int gap);
    logic acc;
    in_valid = 1'b1;
    pixel_in = v;
    acc = 1'b0;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) timeouts++;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drive_frame(input int gap_max, input bit chk_lat, input int n_pix);
    int g;
    int n;
    n = 0;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) begin
        if (n < n_pix) begin
          g = (gap_max < 0) ? int'($urandom_range(0, 2)) : gap_max;
          push_pixel(img[r][c], g);
          if (chk_lat && r == 2 && c == 1) check_int("no_valid_before_0x22", int'(out_valid), 0);
          if (chk_lat && r == 2 && c == 2) begin
            check_int("first_valid", int'(out_valid), 1);
            check_int("first_r1", int'(pixelr1), 'h00);
            check_int("first_r5", int'(pixelr5), 'h11);
            check_int("first_r9", int'(pixelr9), 'h22);
          end
          n++;
        end
      end
    in_valid = 1'b0;
  endtask

  task automatic compare_frames(input string tag);
    logic [WW-1:0] o;
    logic [WW-1:0] e;
    int have;
    for (int k = 0; k < 300 && (obs_q.size() - obs_rd) < exp_q.size(); k++) @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
    have = obs_q.size() - obs_rd;
    check_int({tag, "_count"}, have, exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_rd < obs_q.size()) begin
        o = obs_q[obs_rd];
        obs_rd++;
      end else begin
        o = 'x;
      end
      check_word({tag, "_window"}, o, e);
    end
    obs_rd = obs_q.size();
    check_int({tag, "_timeouts"}, timeouts, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int ov0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    pixel_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_int("rst_out_valid", int'(out_valid), 0);
    check_int("rst_frame_done", int'(frame_done), 0);
    check_int("rst_in_ready", int'(in_ready), 1);
    check_word("rst_window", dut_word(), '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Continuous small frame.
    fill_img(1'b0);
    expect_frame();
    ov0 = ov_cycles;
    drive_frame(0, 1'b1, IMG_W * IMG_H);
    compare_frames("s1");
    check_int("s1_valid_cycles", ov_cycles - ov0, (IMG_W - 2) * (IMG_H - 2));

    // Toggled downstream ready 1,0,0,1.
    ready_mode = 1;
    expect_frame();
    drive_frame(0, 1'b0, IMG_W * IMG_H);
    compare_frames("s2");
    check_int("s2_stall_stable", stall_bad, 0);
    check_int("s2_in_ready_rule", ready_bad, 0);
    ready_mode = 0;

    // Two back-to-back frames.
    expect_frame();
    expect_frame();
    drive_frame(0, 1'b0, IMG_W * IMG_H);
    drive_frame(0, 1'b0, IMG_W * IMG_H);
    compare_frames("s3");

    // Reset after 10 pixels, then a fresh frame.
    drive_frame(0, 1'b0, 10);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_int("s4_valid_in_reset", int'(out_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    check_int("s4_valid_in_reset2", int'(out_valid), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_frame();
    drive_frame(0, 1'b1, IMG_W * IMG_H);
    compare_frames("s4");

    // Input gaps: one pixel every 3 cycles.
    expect_frame();
    ov0 = ov_cycles;
    drive_frame(2, 1'b0, IMG_W * IMG_H);
    compare_frames("s5");
    check_int("s5_valid_cycles", ov_cycles - ov0, (IMG_W - 2) * (IMG_H - 2));

    // Random pixels, random gaps, random downstream ready.
    ready_mode = 2;
    for (int f = 0; f < 3; f++) begin
      fill_img(1'b1);
      expect_frame();
      drive_frame(-1, 1'b0, IMG_W * IMG_H);
    end
    compare_frames("s6");
    ready_mode = 0;
    check_int("stall_stable_all", stall_bad, 0);
    check_int("in_ready_rule_all", ready_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/line_window_3x3.md
Name: line_window_3x3

Overview:
- Streaming 3x3 neighbourhood generator for the image filter datapath.
- Accepts a raster-order pixel stream and keeps two on-chip line buffers of IMG_W pixels each.
- Emits one 9-pixel window per accepted pixel once a full window exists, using valid/ready on both sides.
- Parametrised in pixel width and frame size; replaces fixed-size, fixed-stride window readout from a preloaded frame memory.

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_W, 258, pixels per line; legal range 3..4096.
- IMG_H, 34, lines per frame; legal range 3..4096.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  pixel_in holds a valid pixel.
- in_ready  out  1  block can accept a pixel this cycle.
- pixel_in  in  DATA_W  input pixel, raster order (left to right, top to bottom).
- out_valid  out  1  window outputs hold a valid window.
- out_ready  in  1  downstream accepts the window.
- pixelr1..pixelr9  out  DATA_W each  window pixels, row-major. pixelr1 is top-left (r-2,c-2), pixelr5 is centre (r-1,c-1), pixelr9 is bottom-right (r,c), the newest pixel.
- frame_done  out  1  qualified by out_valid; marks the last window of the frame.

Behaviour:
- Reset (asynchronous, active-low): col=0, row=0, out_valid=0, frame_done=0, pixelr1..9=0. Line buffer contents are undefined and are never used before being rewritten.
- in_ready = !out_valid || out_ready, combinational. An input accept is in_valid && in_ready.
- On accept of pixel P at (row,col), with lb0[col] holding (row-1,col) and lb1[col] holding (row-2,col):
  - Shift the three per-row 3-tap registers left by one. New taps: top<=lb1[col], mid<=lb0[col], bot<=P.
  - Write lb1[col]<=lb0[col] and lb0[col]<=P. Reads return the pre-write values; a read and write to the same address in one cycle are both required.
  - Advance counters: col wraps at IMG_W-1 to 0; on that wrap row increments, and row wraps at IMG_H-1 to 0. The next frame starts immediately, with no gap cycle.
- Output register, latency 1 cycle from accept:
  - out_valid is set on the cycle after an accept where row>=2 and col>=2; pixelr1..9 update at the same time.
  - frame_done is set with that window if the accepted pixel was (IMG_H-1, IMG_W-1).
  - An accept that does not complete a window, with out_ready=1 or out_valid=0, clears out_valid.
- Backpressure: while out_valid=1 and out_ready=0, in_ready=0 and all outputs and state hold. No pixel is lost or duplicated.
- Simultaneous out_ready=1 and a new accept: the current window retires and the next loads in the same cycle. This gives full throughput of 1 pixel per clock.
- Windows per frame: (IMG_W-2)*(IMG_H-2). Columns 0..1 and rows 0..1 produce no output (valid-region mode, no padding).
- Reset mid-frame: counters return to 0 and out_valid drops immediately (asynchronously). The next accepted pixel is treated as (0,0).
- Counter widths: $clog2(IMG_W) and $clog2(IMG_H). No other arithmetic.

Optional Feature:
- Macro LINE_WINDOW_COORD_EN.
- When defined:
  - Add ports out_x (out, $clog2(IMG_W)) and out_y (out, $clog2(IMG_H)).
  - They carry the column and row of the window centre pixelr5, i.e. col-1 and row-1 of the completing pixel.
  - Registered with the window; reset to 0; hold under backpressure.
- When undefined: the ports and their registers do not exist. All other behaviour is identical.

Test Plan:
- Small frame: IMG_W=6, IMG_H=5, pixel=row*16+col, in_valid=1 and out_ready=1 continuously.
  - First out_valid one cycle after pixel 0x22 is accepted, with pixelr1=0x00, pixelr5=0x11, pixelr9=0x22.
  - Exactly 12 windows in total.
  - The last window has pixelr9=0x45 with frame_done=1.
- Same frame, out_ready toggled 1,0,0,1 repeatedly: in_ready=0 while the window is stalled, window values are stable, and the output sequence is identical to the first scenario.
- Two back-to-back frames with no gap: the second frame produces the same 12 windows. No window mixes frame 1 and frame 2 rows; the first window of frame 2 is 0x00..0x22.
- rst_n asserted after 10 pixels, then the frame restarted: out_valid=0 during reset, and the output afterwards matches the first scenario exactly.
- in_valid gaps (1 pixel every 3 cycles) with out_ready=1: same 12 windows, and out_valid is high for exactly one cycle per window.
- With LINE_WINDOW_COORD_EN defined: out_x/out_y run (1,1),(2,1)..(4,1),(1,2)..(4,3) alongside the windows.
